// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl -- address/enable sequencer for an in-place radix-2 DIF FFT
// over N = 2**LOG2N points, driving one external butterfly PE.
//
// Optional feature macro: FFT_SEQ_INVERSE_EN
//   defined   : inverse is latched on an accepted start, and tf_conj follows it
//               on every read cycle.
//   undefined : inverse is ignored and tf_conj is tied low.
//
// Ports:
//   Clk, Reset_n          clock (rising edge), async active-low reset
//   start, inverse, hold  start pulse, inverse request, whole-block stall
//   busy, done            transform in progress / sticky completion flag
//   stage, last_stage     current stage index, final-stage hint (while busy)
//   rd_en, rd_addr_a/b    butterfly operand read request and addresses
//   tf_addr, tf_conj      twiddle ROM index and conjugate select, aligned with rd_en
//   wr_en, wr_addr_a/b    write-back, PIPE_LAT non-held cycles after the read
module fft_seq_ctrl #(
    parameter int LOG2N    = 8,
    parameter int PIPE_LAT = 2,
    parameter int AW       = LOG2N
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          inverse,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [3:0]    stage,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tf_addr,
    output logic          tf_conj,
    output logic          last_stage,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } wb_t;

    state_e        state_q, state_d;
    logic [3:0]    stage_q, stage_d;
    logic [AW-2:0] b_q, b_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;

    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [AW-2:0] tf_q, tf_d;
    wb_t           pipe_q [PIPE_LAT];

    int            sh;
    logic [AW-1:0] span, mask, bw;

    // Control FSM; outputs are registered from the next-state values so that
    // address, twiddle and rd_en all appear together in the issuing cycle.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                stage_d = '0;
                b_d     = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                accept  = 1'b1;
            end
            RUN: begin
                if (&b_q) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DRAIN: begin
                // Next stage's reads start only once the final write of this
                // stage has left the delay line.
                if (dcnt_q == 4'(PIPE_LAT - 1)) begin
                    if (stage_q == 4'(LOG2N - 1)) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 4'd1;
                        b_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterfly addressing: span = N >> (s+1) = 1 << sh.
    always_comb begin
        rd_en_d = (state_d == RUN);
        sh      = LOG2N - 1 - int'(stage_d);
        span    = AW'(1) << sh;
        mask    = span - AW'(1);
        bw      = {1'b0, b_d};
        rd_a_d  = '0;
        rd_b_d  = '0;
        tf_d    = '0;
        if (rd_en_d) begin
            rd_a_d = ((bw >> sh) << (sh + 1)) | (bw & mask);
            rd_b_d = rd_a_d + span;
            tf_d   = (b_d & mask[AW-2:0]) << stage_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            b_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tf_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
        end else if (!hold) begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            b_q       <= b_d;
            dcnt_q    <= dcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            tf_q      <= tf_d;
            pipe_q[0] <= '{en: rd_en_q, a: rd_a_q, b: rd_b_q};
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

`ifdef FFT_SEQ_INVERSE_EN
    logic conj_q, conj_d, tfc_q;

    always_comb begin
        conj_d = accept ? inverse : conj_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            conj_q <= 1'b0;
            tfc_q  <= 1'b0;
        end else if (!hold) begin
            conj_q <= conj_d;
            tfc_q  <= rd_en_d & conj_d;
        end
    end

    assign tf_conj = tfc_q;
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign tf_conj        = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign stage      = stage_q;
    assign last_stage = busy_q && (stage_q == 4'(LOG2N - 1));
    assign rd_en      = rd_en_q;
    assign rd_addr_a  = rd_a_q;
    assign rd_addr_b  = rd_b_q;
    assign tf_addr    = tf_q;
    assign wr_en      = pipe_q[PIPE_LAT-1].en;
    assign wr_addr_a  = pipe_q[PIPE_LAT-1].a;
    assign wr_addr_b  = pipe_q[PIPE_LAT-1].b;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl (LOG2N=4, PIPE_LAT=2). Expected
// outputs come from a cycle-indexed model: k counts non-held cycles since
// the start-accept edge, and every output is derived from k arithmetically.
module tb_fft_seq_ctrl;
    localparam int LOG2N = 4;
    localparam int PL    = 2;
    localparam int AW    = LOG2N;
    localparam int N     = 1 << LOG2N;
    localparam int P     = N / 2 + PL;   // cycles per stage
    localparam int T     = LOG2N * P;    // accept edge to busy falling

    typedef struct packed {
        logic          busy, done, rd_en;
        logic [AW-1:0] a, b;
        logic [AW-2:0] tf;
        logic          conj, last, wr_en;
        logic [AW-1:0] wa, wb;
    } obs_t;

    logic          Clk, Reset_n, start, inverse, hold;
    logic          busy, done, rd_en, tf_conj, last_stage, wr_en;
    logic [3:0]    stage;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [AW-2:0] tf_addr;
    obs_t          obs;
    int            errors = 0;
    int            checks = 0;

    fft_seq_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(PL), .AW(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .inverse(inverse), .hold(hold),
        .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tf_addr(tf_addr),
        .tf_conj(tf_conj), .last_stage(last_stage), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    assign obs = {busy, done, rd_en, rd_addr_a, rd_addr_b, tf_addr, tf_conj,
                  last_stage, wr_en, wr_addr_a, wr_addr_b};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Read issued in non-held cycle k: stage k/P, butterfly k%P while < N/2.
    function automatic void rd_at(input int k, output logic en, output logic [AW-1:0] a,
                                  output logic [AW-1:0] b, output logic [AW-2:0] tf);
        int s, w, span, ai;
        en = 1'b0; a = '0; b = '0; tf = '0;
        if (k >= 0 && k < T) begin
            s = k / P;
            w = k % P;
            if (w < N / 2) begin
                span = N >> (s + 1);
                ai   = (w / span) * 2 * span + (w % span);
                en   = 1'b1;
                a    = AW'(ai);
                b    = AW'(ai + span);
                tf   = (AW-1)'((w % span) * (1 << s));
            end
        end
    endfunction

    function automatic obs_t model(input int k, input logic inv);
        obs_t e;
        logic en;
        logic [AW-1:0] a, b;
        logic [AW-2:0] tf;
        e = '0;
        rd_at(k, en, a, b, tf);
        e.rd_en = en; e.a = a; e.b = b; e.tf = tf;
`ifdef FFT_SEQ_INVERSE_EN
        e.conj = en & inv;
`else
        e.conj = 1'b0 & inv;
`endif
        e.busy = (k < T);
        e.done = (k >= T + 1);
        e.last = (k < T) && (k / P == LOG2N - 1);
        rd_at(k - PL, en, a, b, tf);
        e.wr_en = en; e.wa = a; e.wb = b;
        return e;
    endfunction

    task automatic do_start(input logic inv);
        @(negedge Clk);
        hold = 1'b0; start = 1'b1; inverse = inv;
        @(posedge Clk);
        #1 start = 1'b0; inverse = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; start = 1'b0; inverse = 1'b0; hold = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (obs !== '0 || stage !== 4'd0) begin
            errors++; $display("FAIL reset_state got=%h/%0d exp=0/0", obs, stage);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL idle_after_reset got=%h exp=0", obs); end
    endtask

    task automatic test_basic();
        obs_t e;
        int fall = -1;
        do_start(1'b1);
        for (int k = 0; k <= T + 5; k++) begin
            @(negedge Clk);
            e = model(k, 1'b1);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs, e); end
            if (e.busy) begin
                checks++;
                if (stage !== 4'(k / P)) begin
                    errors++; $display("FAIL basic_stage k=%0d got=%0d exp=%0d", k, stage, k / P);
                end
            end
            if (k == 3 || k == 15 || k == 35) begin
                checks++;
                if ((k == 3  && {rd_addr_a, rd_addr_b, tf_addr, last_stage} !== {4'd3,  4'd11, 3'd3, 1'b0}) ||
                    (k == 15 && {rd_addr_a, rd_addr_b, tf_addr, last_stage} !== {4'd9,  4'd13, 3'd2, 1'b0}) ||
                    (k == 35 && {rd_addr_a, rd_addr_b, tf_addr, last_stage} !== {4'd10, 4'd11, 3'd0, 1'b1})) begin
                    errors++; $display("FAIL spot_addr k=%0d got=%h,%h,%h,%b", k, rd_addr_a, rd_addr_b, tf_addr, last_stage);
                end
            end
            if (!busy && fall < 0) fall = k;
        end
        checks++;
        if (fall !== 40) begin errors++; $display("FAIL basic_latency got=%0d exp=40", fall); end
    endtask

    task automatic test_hold_idle();
        @(negedge Clk);
        hold = 1'b1; start = 1'b1;
        repeat (2) @(negedge Clk);
        hold = 1'b0; start = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({busy, done, rd_en} !== 3'b010) begin
            errors++; $display("FAIL hold_idle busy/done/rd got=%b exp=010", {busy, done, rd_en});
        end
    endtask

    task automatic test_hold();
        obs_t e;
        int keff = 0;
        int fall = -1;
        logic h;
        do_start(1'b0);
        for (int c = 0; c < T + 10; c++) begin
            @(negedge Clk);
            e = model(keff, 1'b0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL hold c=%0d k=%0d got=%h exp=%h", c, keff, obs, e); end
            if (!busy && fall < 0) fall = c;
            h = (c >= 3 && c <= 5) || (c == 11);
            hold = h;
            if (!h) keff++;
        end
        hold = 1'b0;
        checks++;
        if (fall !== 44) begin errors++; $display("FAIL hold_latency got=%0d exp=44", fall); end
    endtask

    task automatic test_abort();
        obs_t e;
        do_start(1'b0);
        for (int k = 0; k < 23; k++) begin
            @(negedge Clk);
            e = model(k, 1'b0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL pre_abort k=%0d got=%h exp=%h", k, obs, e); end
        end
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || stage !== 4'd0) begin
            errors++; $display("FAIL async_reset got=%h/%0d exp=0/0", obs, stage);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL post_abort got=%h exp=0", obs); end
        end
        do_start(1'b0);
        for (int k = 0; k <= T + 3; k++) begin
            @(negedge Clk);
            e = model(k, 1'b0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rerun k=%0d got=%h exp=%h", k, obs, e); end
            start = (k == 5) || (k == 20);
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        obs_t e;
        int keff, cyc;
        logic inv, h;
        for (int run = 0; run < 3; run++) begin
            inv  = 1'($urandom_range(0, 1));
            keff = 0;
            cyc  = 0;
            do_start(inv);
            while (keff <= T + 2 && cyc < 400) begin
                @(negedge Clk);
                e = model(keff, inv);
                checks++;
                if (obs !== e) begin
                    errors++; $display("FAIL random r=%0d k=%0d got=%h exp=%h", run, keff, obs, e);
                end
                h = ($urandom_range(0, 3) == 0);
                hold  = h;
                start = 1'($urandom_range(0, 1)) & (keff < T - 2);
                if (!h) keff++;
                cyc++;
            end
            hold = 1'b0; start = 1'b0;
            checks++;
            if (cyc >= 400) begin errors++; $display("FAIL random_timeout r=%0d k=%0d exp<=%0d", run, keff, T + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_idle();
        test_hold();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
